// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store initiator for the word-indexed data memory.
// Byte/half/word accesses; sub-word stores use read-modify-write.
module mem_stage_lsu #(
    parameter int MEM_WORDS = 10240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP
    } state_t;

    localparam logic [29:0] LIMIT = 30'(MEM_WORDS);

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        signed_q;
    logic        err_q;
    logic        req_err;
    logic        accept;

    function automatic logic [31:0] load_ext(
        input logic [31:0] w,
        input logic [1:0]  off,
        input logic [1:0]  sz,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(
        input logic [31:0] w,
        input logic [1:0]  off,
        input logic [1:0]  sz,
        input logic [31:0] d
    );
        logic [31:0] r;
        r = w;
        if (sz == 2'b00) begin
            r[{off, 3'b000} +: 8] = d[7:0];
        end else if (off[1]) begin
            r[31:16] = d[15:0];
        end else begin
            r[15:0] = d[15:0];
        end
        return r;
    endfunction

    assign req_err = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                   | (req_addr[31:2] >= LIMIT);

    assign accept = (state_q == IDLE) & req_valid;

    always_comb begin
        state_d   = state_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = 32'h0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)                state_d = RESP;
                    else if (!req_we)           state_d = LOAD;
                    else if (req_size == 2'b10) state_d = STORE;
                    else                        state_d = RMW_RD;
                end
            end
            LOAD: begin
                mem_read = 1'b1;
                state_d  = RESP;
            end
            STORE: begin
                mem_write = 1'b1;
                mem_wdata = wdata_q;
                state_d   = RESP;
            end
            RMW_RD: begin
                mem_read = 1'b1;
                state_d  = RMW_WR;
            end
            RMW_WR: begin
                mem_write = 1'b1;
                mem_wdata = merge(merge_q, addr_q[1:0], size_q, wdata_q);
                state_d   = RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            size_q   <= '0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                size_q   <= req_size;
                we_q     <= req_we;
                signed_q <= req_signed;
                err_q    <= req_err;
                rdata_q  <= '0;
            end
            if (state_q == LOAD && !we_q) begin
                rdata_q <= load_ext(mem_rdata, addr_q[1:0], size_q, signed_q);
            end
            if (state_q == RMW_RD) begin
                merge_q <= mem_rdata;
            end
        end
    end

    // Address comes from the captured request so it stays put until the next accept
    assign mem_addr   = {2'b00, addr_q[31:2]};
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a small behavioural data memory.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write, busy;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic [31:0] mem [0:63];
    int checks = 0;
    int failures = 0;
    int wr_total = 0;
    int overlap = 0;
    int lat, nr, nw;
    logic [31:0] w_addr, w_data;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always @(negedge clk) begin
        if (mem_read) mem_rdata <= mem[mem_addr[5:0]];
        if (mem_read && mem_write) overlap++;
    end

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[5:0]] <= mem_wdata;
            wr_total++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp();
        lat = 1; nr = 0; nw = 0;
        w_addr = 'x; w_data = 'x;
        while (!resp_valid && lat < 10) begin
            if (mem_write) begin
                nw++;
                w_addr = mem_addr;
                w_data = mem_wdata;
            end
            if (mem_read) nr++;
            tick();
            lat++;
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a,
                          input logic [31:0] d);
        req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = d; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        wait_resp();
    endtask

    task automatic chk_err(input string tag);
        chk({tag, "_lat"}, lat, 1);
        chk({tag, "_err"}, resp_err, 1);
        chk({tag, "_rdata"}, resp_rdata, 0);
        chk({tag, "_rw"}, nr + nw, 0);
        tick();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_rdata"}, resp_rdata, 0);
        chk({tag, "_err"}, resp_err, 0);
        chk({tag, "_mem_rw"}, {mem_read, mem_write}, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int snap;
        logic [31:0] held;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
        #2;
        chk_reset_outs("rst");
        @(negedge clk);
        rst = 1'b0;
        tick();

        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        chk("sw_lat", lat, 2);
        chk("sw_nw", nw, 1);
        chk("sw_addr", w_addr, 32'd4);
        chk("sw_wdata", w_data, 32'hDEADBEEF);
        chk("sw_err", resp_err, 0);
        chk("sw_mem", mem[4], 32'hDEADBEEF);
        tick();

        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("lw_lat", lat, 2);
        chk("lw_rdata", resp_rdata, 32'hDEADBEEF);
        chk("lw_err", resp_err, 0);
        tick();

        mem[4] = 32'h11223344;
        do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h123456AA);
        chk("sb_lat", lat, 3);
        chk("sb_nr", nr, 1);
        chk("sb_nw", nw, 1);
        chk("sb_wdata", w_data, 32'h11AA3344);
        chk("sb_err", resp_err, 0);
        tick();

        do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
        chk("lb_s", resp_rdata, 32'hFFFFFFAA);
        tick();
        do_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
        chk("lb_u", resp_rdata, 32'h000000AA);
        tick();
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        chk("lh_s_hi", resp_rdata, 32'h000011AA);
        tick();
        do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
        chk("lb_s_pos", resp_rdata, 32'h00000044);
        tick();

        do_req(1'b1, 2'b01, 1'b0, 32'h10, 32'hFFFF8001);
        chk("sh_lat", lat, 3);
        chk("sh_wdata", w_data, 32'h11AA8001);
        tick();
        do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
        chk("lh_s_neg", resp_rdata, 32'hFFFF8001);
        tick();

        mem[63] = 32'hCAFEF00D;
        do_req(1'b0, 2'b10, 1'b0, 32'h00009FFC, 32'h0);
        chk("lw_last_err", resp_err, 0);
        chk("lw_last_rdata", resp_rdata, 32'hCAFEF00D);
        tick();

        do_req(1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
        chk_err("e_half");
        do_req(1'b1, 2'b10, 1'b0, 32'h0E, 32'h12345678);
        chk_err("e_word");
        chk("e_word_mem", mem[3], 32'h0);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        chk_err("e_size");
        do_req(1'b0, 2'b10, 1'b0, 32'h0000A000, 32'h0);
        chk_err("e_range");

        resp_ready = 1'b0;
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        held = resp_rdata;
        chk("bp_rdata0", held, 32'h11AA8001);
        req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h12; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", resp_valid, 1);
            chk("bp_rdata", resp_rdata, 32'h11AA8001);
            chk("bp_err", resp_err, 0);
            chk("bp_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        tick();
        chk("bp_idle", req_ready, 1);
        tick();
        chk("bp_accept_busy", busy, 1);
        chk("bp_accept_rd", mem_read, 1);
        req_valid = 1'b0;
        wait_resp();
        chk("bp_next_rdata", resp_rdata, 32'h000000AA);
        tick();

        mem[5] = 32'h55667788;
        snap = wr_total;
        req_we = 1'b1; req_size = 2'b00; req_addr = 32'h14;
        req_wdata = 32'h000000EE; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("ar_in_rmw_rd", mem_read, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outs("ar");
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        chk("ar_no_write", wr_total - snap, 0);
        chk("ar_mem", mem[5], 32'h55667788);
        chk("ar_no_resp", resp_valid, 0);
        chk("overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Load/store initiator for the pipeline MEM stage, driving the word-indexed data memory (MemRead/MemWrite/Address/WriteVal/Out) on the core's behalf. It takes byte-addressed requests over a valid/ready handshake and supports byte, half and word sizes with optional sign extension. Sub-word stores are done as read-modify-write. It returns one response per request and flags misaligned, out-of-range and invalid-size accesses without touching memory.

Parameters:
MEM_WORDS, 10240, depth of the attached data memory in 32-bit words; word index >= MEM_WORDS is out of range

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 invalid
req_signed  input  1  loads only: sign-extend (1) or zero-extend (0)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  32  load result, extended; 0 for stores and errors
resp_err  output  1  request was rejected: misaligned, out of range or size 11
mem_read  output  1  to memory MemRead
mem_write  output  1  to memory MemWrite
mem_addr  output  32  to memory Address, word index = captured req_addr[31:2] zero-extended
mem_wdata  output  32  to memory WriteVal
mem_rdata  input  32  from memory Out (memory updates it on negedge while mem_read=1)
busy  output  1  state != IDLE

Behaviour:
- FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- Accept: a request is accepted at the posedge where req_valid & req_ready. On acceptance, addr, we, size, signed and wdata are captured into registers.
- Error check at accept:
  - err if size=11, or size=01 & addr[0], or size=10 & addr[1:0]!=0, or addr[31:2] >= MEM_WORDS.
  - On err: go directly to RESP with resp_err=1 and resp_rdata=0.
  - mem_read and mem_write never assert for an erroring request.
- Transitions out of IDLE when there is no error:
  - load -> LOAD
  - store word -> STORE
  - store byte/half -> RMW_RD
- LOAD: mem_read=1 for exactly one cycle. At the closing posedge, mem_rdata is sampled, then lane-selected and extended into resp_rdata. Next state RESP.
- Lane selection, little-endian:
  - byte offset k selects bits [8k+7:8k].
  - half at addr[1]=0 selects [15:0]; addr[1]=1 selects [31:16].
  - sign extension from bit 7 or 15 when req_signed=1, else zero extension.
  - word passes through unchanged; req_signed is ignored.
- STORE: mem_write=1 and mem_wdata=captured wdata for one cycle. Next state RESP.
- RMW_RD: mem_read=1 for one cycle. At the closing posedge, mem_rdata is latched into the merge register. Next state RMW_WR.
- RMW_WR: mem_write=1 for one cycle. mem_wdata = latched word with the target byte (wdata[7:0]) or half (wdata[15:0]) replaced in its lane; other lanes keep their old value. Next state RESP.
- RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_ready is sampled high, then the FSM returns to IDLE. A new request is not accepted in the same edge (req_ready=0 in RESP).
- Latency, counted as cycles from the accept edge to the edge at which resp_valid is first seen high:
  - load / word store: 2
  - sub-word store: 3
  - error: 1
- Register and output timing:
  - mem_read, mem_write, mem_addr and mem_wdata depend only on state and captured registers, never on req_* inputs.
  - mem_addr is held constant for the whole request, IDLE through RESP.
  - mem_read and mem_write are never high together.
- Reset values (all outputs): req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, busy=0. All captured registers clear to 0.
- Reset mid-operation: state forced to IDLE immediately. Any pending write not yet clocked is dropped, and no response is produced for the aborted request.
- Back-to-back requests: req_valid may stay high; the next request is accepted the cycle after RESP completes.

Test Plan:
- Word store then load: store addr 0x00000010, wdata 0xDEADBEEF.
  - mem_write=1 for one cycle with mem_addr=4, mem_wdata=0xDEADBEEF.
  - resp_err=0.
  - Then load word from 0x10 -> resp_rdata=0xDEADBEEF.
- Byte RMW: memory word 4 = 0x11223344; store byte 0xAA to addr 0x12.
  - RMW_RD cycle, then RMW_WR with mem_wdata=0x11AA3344.
  - resp_valid 3 cycles after accept.
- Sign/zero extension: word 4 = 0x11AA3344.
  - signed byte load at 0x12 -> 0xFFFFFFAA.
  - unsigned byte load at 0x12 -> 0x000000AA.
  - signed half load at 0x12 -> 0x000011AA.
- Errors, each giving resp_err=1, resp_rdata=0, with mem_read and mem_write staying 0 throughout:
  - half load at 0x13
  - word store at 0x0E
  - size=11
  - word load at 0x0000A000 (index 10240)
- Response backpressure: hold resp_ready=0 for 5 cycles after a load.
  - resp_valid, resp_rdata and resp_err stay stable.
  - req_ready stays 0.
  - After resp_ready=1, the next queued request is accepted the following cycle.
- Async reset during RMW_RD of a byte store:
  - All outputs return to reset values without waiting for a clock edge.
  - mem_write never asserts.
  - The memory word is unchanged.
